// File: rtl/fp32_pkg.sv
// Shared FP32 constants, state encoding and small helpers used by the
// adder align/normalize stages and by the FP32-to-integer unpacker.
package fp32_pkg;

  localparam int          FP32_BIAS   = 127;
  localparam int          EXP_W       = 8;
  localparam int          FRAC_W      = 23;
  localparam logic [7:0]  EXP_MAX     = 8'hFF;
  localparam logic [31:0] INT32_MIN   = 32'h8000_0000;
  localparam logic [31:0] INT32_MAX   = 32'h7FFF_FFFF;
  localparam logic [31:0] FP32_NEG_2P31 = 32'hCF00_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Mask covering the k low bits that a right shift by k discards.
  function automatic logic [31:0] low_mask(input logic [4:0] k);
    return (32'd1 << k) - 32'd1;
  endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 field decoder: special-value flags, unbiased exponent
// and the 24-bit significand with the hidden one restored.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0]       fp_i,
  output logic              is_nan_o,
  output logic              is_inf_o,
  output logic              is_zero_or_denorm_o,
  output logic signed [8:0] exp_unb_o,
  output logic [23:0]       sig_o
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;

  assign exp_f  = fp_i[30:23];
  assign frac_f = fp_i[22:0];

  assign is_nan_o            = (exp_f == EXP_MAX) && (frac_f != 23'd0);
  assign is_inf_o            = (exp_f == EXP_MAX) && (frac_f == 23'd0);
  assign is_zero_or_denorm_o = (exp_f == 8'd0);
  // Modulo-512 subtraction reinterpreted as signed gives -127..128.
  assign exp_unb_o           = $signed({1'b0, exp_f} - 9'(FP32_BIAS));
  assign sig_o               = {(exp_f != 8'd0), frac_f};

endmodule

// File: rtl/fp32_to_int32.sv
// FP32 to signed int32 conversion (round toward zero) using an iterative
// right shifter with valid/ready handshakes on input and output.
module fp32_to_int32
  import fp32_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = 4,
  parameter logic [31:0] NAN_VALUE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_fp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_int,
  output logic        out_invalid,
  output logic        out_inexact
);

  localparam logic [4:0] STEP_W = 5'(SHIFT_STEP);

  state_e      state_q;
  logic [31:0] acc_q;
  logic [4:0]  rem_q;
  logic        sticky_q;
  logic        sign_q;
  logic [31:0] out_int_q;
  logic        out_valid_q;
  logic        in_ready_q;
  logic        out_invalid_q;
  logic        out_inexact_q;

  logic              is_nan_s;
  logic              is_inf_s;
  logic              is_zod_s;
  logic signed [8:0] exp_unb_s;
  logic [23:0]       sig_s;

  logic        is_special_s;
  logic [31:0] spec_int_s;
  logic        spec_inv_s;
  logic        spec_inx_s;

  logic [31:0] src_acc_s;
  logic [4:0]  src_rem_s;
  logic        src_sticky_s;
  logic        src_sign_s;
  logic [4:0]  k_s;
  logic [31:0] acc_d;
  logic [4:0]  rem_d;
  logic        sticky_d;
  logic [31:0] res_d;

  fp32_classify u_classify (
    .fp_i                (in_fp),
    .is_nan_o            (is_nan_s),
    .is_inf_o            (is_inf_s),
    .is_zero_or_denorm_o (is_zod_s),
    .exp_unb_o           (exp_unb_s),
    .sig_o               (sig_s)
  );

  // Special-case result for operands that bypass the shifter.
  always_comb begin
    is_special_s = 1'b1;
    spec_int_s   = 32'd0;
    spec_inv_s   = 1'b0;
    spec_inx_s   = 1'b0;
    if (is_nan_s) begin
      spec_int_s = NAN_VALUE;
      spec_inv_s = 1'b1;
    end else if (is_inf_s || (exp_unb_s >= 9'sd31)) begin
      if (in_fp == FP32_NEG_2P31) begin
        spec_int_s = INT32_MIN;
      end else begin
        spec_int_s = in_fp[31] ? INT32_MIN : INT32_MAX;
        spec_inv_s = 1'b1;
      end
    end else if (is_zod_s || exp_unb_s[8]) begin
      spec_inx_s = (in_fp[30:0] != 31'd0);
    end else begin
      is_special_s = 1'b0;
    end
  end

  // One shifter step; in IDLE it operates on the freshly unpacked operand so
  // the accept edge already performs the first shift.
  always_comb begin
    if (state_q == IDLE) begin
      src_acc_s    = {sig_s, 8'd0};
      src_rem_s    = 5'd31 - exp_unb_s[4:0];
      src_sticky_s = 1'b0;
      src_sign_s   = in_fp[31];
    end else begin
      src_acc_s    = acc_q;
      src_rem_s    = rem_q;
      src_sticky_s = sticky_q;
      src_sign_s   = sign_q;
    end
    k_s      = (src_rem_s > STEP_W) ? STEP_W : src_rem_s;
    acc_d    = src_acc_s >> k_s;
    sticky_d = src_sticky_s | (|(src_acc_s & low_mask(k_s)));
    rem_d    = src_rem_s - k_s;
    res_d    = src_sign_s ? (32'd0 - acc_d) : acc_d;
  end

  // Control FSM, shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= 32'd0;
      rem_q         <= 5'd0;
      sticky_q      <= 1'b0;
      sign_q        <= 1'b0;
      out_int_q     <= 32'd0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
      out_invalid_q <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            sign_q     <= in_fp[31];
            if (is_special_s) begin
              state_q       <= DONE;
              out_valid_q   <= 1'b1;
              out_int_q     <= spec_int_s;
              out_invalid_q <= spec_inv_s;
              out_inexact_q <= spec_inx_s;
            end else if (rem_d == 5'd0) begin
              state_q       <= DONE;
              out_valid_q   <= 1'b1;
              out_int_q     <= res_d;
              out_invalid_q <= 1'b0;
              out_inexact_q <= sticky_d;
            end else begin
              state_q  <= SHIFT;
              acc_q    <= acc_d;
              rem_q    <= rem_d;
              sticky_q <= sticky_d;
            end
          end
        end
        SHIFT: begin
          acc_q    <= acc_d;
          rem_q    <= rem_d;
          sticky_q <= sticky_d;
          if (rem_d == 5'd0) begin
            state_q       <= DONE;
            out_valid_q   <= 1'b1;
            out_int_q     <= res_d;
            out_invalid_q <= 1'b0;
            out_inexact_q <= sticky_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_int     = out_int_q;
  assign out_invalid = out_invalid_q;
  assign out_inexact = out_inexact_q;

endmodule
